// File: rtl/axis_pkg.sv
// Shared AXI-stream definitions: default widths, the beat record and the FIFO pointer width helper.
package axis_pkg;

  localparam int AXIS_DATA_W = 64;
  localparam int AXIS_USER_W = 1;

  typedef struct packed {
    logic [AXIS_DATA_W-1:0] data;
    logic                   last;
    logic [AXIS_USER_W-1:0] user;
  } axis_beat_t;

  // One extra MSB beyond the index distinguishes full from empty when indices match.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/axis_fifo_ram.sv
// Beat storage for the egress FIFO: one synchronous write port, combinational read port.
module axis_fifo_ram #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 66
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Contents are deliberately not reset; the pointers alone define validity.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/axis_egress_fifo.sv
// Frame-aware first-word-fall-through AXI-stream FIFO ahead of axis_egress; tracks beats and whole frames held.
module axis_egress_fifo
  import axis_pkg::*;
#(
  parameter int DATA_WIDTH = AXIS_DATA_W,
  parameter int USER_WIDTH = AXIS_USER_W,
  parameter int DEPTH      = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [DATA_WIDTH-1:0]      s_tdata,
  input  logic                       s_tvalid,
  output logic                       s_tready,
  input  logic                       s_tlast,
  input  logic [USER_WIDTH-1:0]      s_tuser,
  output logic [DATA_WIDTH-1:0]      m_tdata,
  output logic                       m_tvalid,
  input  logic                       m_tready,
  output logic                       m_tlast,
  output logic [USER_WIDTH-1:0]      m_tuser,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic [$clog2(DEPTH+1)-1:0] frames
);

  localparam int PW = ptr_w(DEPTH);
  localparam int AW = PW - 1;
  localparam int LW = $clog2(DEPTH + 1);
  localparam int BW = DATA_WIDTH + 1 + USER_WIDTH;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("axis_egress_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [LW-1:0] frames_q, frames_d;
  logic          ready_en_q, ready_en_d;

  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic [BW-1:0] wr_beat;
  logic [BW-1:0] rd_beat;

  assign full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);

  // Ready depends only on local state so m_tready can never create a combinational path upstream.
  assign s_tready = ready_en_q & ~full;
  assign m_tvalid = ~empty;

  assign push = s_tvalid & s_tready;
  assign pop  = m_tvalid & m_tready;

  assign wr_beat = {s_tdata, s_tlast, s_tuser};
  assign {m_tdata, m_tlast, m_tuser} = rd_beat;

  assign level  = level_q;
  assign frames = frames_q;

  axis_fifo_ram #(
    .DEPTH (DEPTH),
    .WIDTH (BW)
  ) u_ram (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_q[AW-1:0]),
    .wdata (wr_beat),
    .raddr (rd_ptr_q[AW-1:0]),
    .rdata (rd_beat)
  );

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    frames_d   = frames_q;
    ready_en_d = 1'b1;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end

    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    // A frame counts once its tlast beat is stored and stops counting once that beat leaves.
    case ({push & s_tlast, pop & m_tlast})
      2'b10:   frames_d = frames_q + LW'(1);
      2'b01:   frames_d = frames_q - LW'(1);
      default: frames_d = frames_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      frames_q   <= '0;
      ready_en_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      frames_q   <= frames_d;
      ready_en_q <= ready_en_d;
    end
  end

endmodule

// File: tb/tb_axis_egress_fifo.sv
// Directed plus randomized bench for axis_egress_fifo, checked against a queue-based reference model.
module tb_axis_egress_fifo;
  import axis_pkg::*;

  localparam int DEPTH = 16;
  localparam int LW    = $clog2(DEPTH + 1);

  logic          clk;
  logic          rst_n;
  logic [63:0]   s_tdata;
  logic          s_tvalid;
  logic          s_tready;
  logic          s_tlast;
  logic [0:0]    s_tuser;
  logic [63:0]   m_tdata;
  logic          m_tvalid;
  logic          m_tready;
  logic          m_tlast;
  logic [0:0]    m_tuser;
  logic [LW-1:0] level;
  logic [LW-1:0] frames;

  int pass_cnt;
  int total_cnt;

  axis_beat_t model_q[$];
  bit         model_ready;
  int         pop_count;
  int         max_level;

  axis_egress_fifo #(
    .DATA_WIDTH (64),
    .USER_WIDTH (1),
    .DEPTH      (DEPTH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_tdata  (s_tdata),
    .s_tvalid (s_tvalid),
    .s_tready (s_tready),
    .s_tlast  (s_tlast),
    .s_tuser  (s_tuser),
    .m_tdata  (m_tdata),
    .m_tvalid (m_tvalid),
    .m_tready (m_tready),
    .m_tlast  (m_tlast),
    .m_tuser  (m_tuser),
    .level    (level),
    .frames   (frames)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  function automatic int model_frames();
    int n = 0;
    foreach (model_q[i]) if (model_q[i].last) n++;
    return n;
  endfunction

  // Compare every visible output with what the queue model says the FIFO should present.
  task automatic check_outputs(input string tag);
    check({tag, "_s_tready"}, 64'(s_tready), 64'(model_ready && model_q.size() < DEPTH));
    check({tag, "_m_tvalid"}, 64'(m_tvalid), 64'(model_q.size() > 0));
    check({tag, "_level"},    64'(level),    64'(model_q.size()));
    check({tag, "_frames"},   64'(frames),   64'(model_frames()));
    if (model_q.size() > 0) begin
      check({tag, "_m_tdata"}, m_tdata,        model_q[0].data);
      check({tag, "_m_tlast"}, 64'(m_tlast),   64'(model_q[0].last));
      check({tag, "_m_tuser"}, 64'(m_tuser),   64'(model_q[0].user));
    end
  endtask

  // One clock: drive inputs, let the edge happen, advance the model, check 1 time unit later.
  task automatic step(input string tag, input bit v, input logic [63:0] d, input bit l,
                      input bit u, input bit r);
    bit         do_push;
    bit         do_pop;
    axis_beat_t b;
    s_tvalid = v;
    s_tdata  = d;
    s_tlast  = l;
    s_tuser  = u;
    m_tready = r;
    do_push = v && model_ready && (model_q.size() < DEPTH);
    do_pop  = r && (model_q.size() > 0);
    @(posedge clk);
    if (do_pop) begin
      b = model_q.pop_front();
      pop_count++;
      $display("pop  data=0x%016h last=%0b user=%0b level_before=%0d", b.data, b.last, b.user,
               model_q.size() + 1);
    end
    if (do_push) begin
      b.data = d;
      b.last = l;
      b.user = u;
      model_q.push_back(b);
    end
    model_ready = 1'b1;
    #1;
    if (model_q.size() > max_level) max_level = model_q.size();
    check_outputs(tag);
  endtask

  initial begin
    pass_cnt    = 0;
    total_cnt   = 0;
    model_ready = 1'b0;
    pop_count   = 0;
    max_level   = 0;
    rst_n       = 1'b0;
    s_tvalid    = 1'b0;
    s_tdata     = '0;
    s_tlast     = 1'b0;
    s_tuser     = '0;
    m_tready    = 1'b0;

    // Reset and the one-edge ready delay after release.
    repeat (5) @(posedge clk);
    #3;
    check_outputs("reset");
    rst_n = 1'b1;
    #1;
    check("release_s_tready", 64'(s_tready), 64'd0);
    step("first_edge", 1'b1, 64'hDEAD, 1'b0, 1'b0, 1'b0);
    check("first_edge_no_push", 64'(level), 64'd0);
    $display("phase reset done");

    // Fill to full, then offer a 17th beat that must be refused.
    for (int i = 0; i < DEPTH; i++) begin
      step("fill", 1'b1, 64'(i), (i == 7) || (i == 15), 1'(i % 2), 1'b0);
    end
    check("fill_level", 64'(level), 64'd16);
    check("fill_frames", 64'(frames), 64'd2);
    check("fill_s_tready", 64'(s_tready), 64'd0);
    step("overflow", 1'b1, 64'h10, 1'b0, 1'b0, 1'b0);
    check("overflow_level", 64'(level), 64'd16);

    // Drain in order.
    for (int i = 0; i < DEPTH; i++) begin
      check("drain_order", m_tdata, 64'(i));
      step("drain", 1'b0, 64'h0, 1'b0, 1'b0, 1'b1);
    end
    check("drain_empty", 64'(m_tvalid), 64'd0);
    check("drain_frames", 64'(frames), 64'd0);

    // Full boundary: simultaneous offer and pop when full yields only the pop.
    for (int i = 0; i < DEPTH; i++) begin
      step("refill", 1'b1, 64'(8'h40 + i), i == 15, 1'b0, 1'b0);
    end
    step("full_boundary", 1'b1, 64'h20, 1'b1, 1'b1, 1'b1);
    check("full_boundary_level", 64'(level), 64'd15);
    step("after_boundary", 1'b1, 64'h20, 1'b1, 1'b1, 1'b0);
    check("after_boundary_level", 64'(level), 64'd16);
    while (model_q.size() > 0) step("drain2", 1'b0, 64'h0, 1'b0, 1'b0, 1'b1);

    // Continuous streaming: 100 beats at one per clock.
    pop_count = 0;
    max_level = 0;
    for (int i = 0; i < 100; i++) begin
      step("stream", 1'b1, {$urandom, $urandom}, 1'($urandom_range(0, 3) == 0), 1'($urandom),
           1'b1);
    end
    check("stream_pops", 64'(pop_count), 64'd99);
    check("stream_level_max", 64'(max_level <= 1), 64'd1);
    step("stream_tail", 1'b0, 64'h0, 1'b0, 1'b0, 1'b1);
    check("stream_empty", 64'(m_tvalid), 64'd0);

    // Random valid/ready mix with AXI-stable upstream data.
    begin
      logic [63:0] d = {$urandom, $urandom};
      bit          l = 1'($urandom);
      bit          u = 1'($urandom);
      bit          v = 1'b0;
      for (int i = 0; i < 400; i++) begin
        if (!v || s_tready) begin
          v = 1'($urandom_range(0, 3) != 0);
          d = {$urandom, $urandom};
          l = 1'($urandom_range(0, 4) == 0);
          u = 1'($urandom);
        end
        step("random", v, d, l, u, 1'($urandom_range(0, 2) == 0));
      end
    end
    while (model_q.size() > 0) step("drain3", 1'b0, 64'h0, 1'b0, 1'b0, 1'b1);

    // Async reset in the middle of a frame.
    for (int i = 0; i < 5; i++) begin
      step("partial", 1'b1, 64'(8'h80 + i), 1'b0, 1'b0, 1'b0);
    end
    s_tvalid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_m_tvalid", 64'(m_tvalid), 64'd0);
    check("async_level", 64'(level), 64'd0);
    check("async_frames", 64'(frames), 64'd0);
    model_q.delete();
    model_ready = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    step("post_reset_edge", 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step("new_frame", 1'b1, 64'(8'hC0 + i), i == 3, 1'b1, 1'b0);
    end
    check("new_frame_frames", 64'(frames), 64'd1);
    for (int i = 0; i < 4; i++) begin
      check("new_frame_data", m_tdata, 64'(8'hC0 + i));
      step("new_frame_drain", 1'b0, 64'h0, 1'b0, 1'b0, 1'b1);
    end
    check("new_frame_empty", 64'(m_tvalid), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
